// File: rtl/spram_pm.sv
// spram_pm: parametrised single-port synchronous RAM with nibble write masks and a
// power-management FSM. Define SPRAM_PM_OUTREG_EN to add an output pipeline register.
module spram_pm #(
    parameter int DW         = 16,
    parameter int AW         = 14,
    parameter int DEPTH      = 2**AW,
    parameter int STBY_WAKE  = 1,
    parameter int SLEEP_WAKE = 4,
    parameter int OFF_WAKE   = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [AW-1:0]     ADDRESS,
    input  logic [DW-1:0]     DATAIN,
    input  logic [DW/4-1:0]   MASKWREN,
    input  logic              WREN,
    input  logic              CHIPSELECT,
    input  logic              STANDBY,
    input  logic              SLEEP,
    input  logic              POWEROFF,
    output logic [DW-1:0]     DATAOUT,
    output logic              DATAVALID,
    output logic              READY,
    output logic              ADDRERR
);

    localparam int NW       = DW / 4;
    localparam int MAX_WAKE = (OFF_WAKE > SLEEP_WAKE)
                              ? ((OFF_WAKE > STBY_WAKE) ? OFF_WAKE : STBY_WAKE)
                              : ((SLEEP_WAKE > STBY_WAKE) ? SLEEP_WAKE : STBY_WAKE);
    localparam int CW       = (MAX_WAKE < 1) ? 1 : $clog2(MAX_WAKE + 1);
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SLEEP  = 3'd1,
        ST_STBY   = 3'd2,
        ST_WAKE   = 3'd3,
        ST_ACTIVE = 3'd4
    } state_t;

    // The release edge itself counts as the first wake cycle, so the counter is
    // preloaded with k-1; a zero latency skips WAKE entirely.
    localparam state_t        OFF_TGT   = (OFF_WAKE   == 0) ? ST_ACTIVE : ST_WAKE;
    localparam state_t        SLEEP_TGT = (SLEEP_WAKE == 0) ? ST_ACTIVE : ST_WAKE;
    localparam state_t        STBY_TGT  = (STBY_WAKE  == 0) ? ST_ACTIVE : ST_WAKE;
    localparam logic [CW-1:0] OFF_LD    = (OFF_WAKE   == 0) ? {CW{1'b0}} : CW'(OFF_WAKE - 1);
    localparam logic [CW-1:0] SLEEP_LD  = (SLEEP_WAKE == 0) ? {CW{1'b0}} : CW'(SLEEP_WAKE - 1);
    localparam logic [CW-1:0] STBY_LD   = (STBY_WAKE  == 0) ? {CW{1'b0}} : CW'(STBY_WAKE - 1);

    function automatic logic [DW-1:0] merge_nibbles(input logic [DW-1:0] old_word,
                                                    input logic [DW-1:0] new_word,
                                                    input logic [NW-1:0] mask);
        logic [DW-1:0] res;
        res = old_word;
        for (int i = 0; i < NW; i++) begin
            if (mask[i]) begin
                res[4*i +: 4] = new_word[4*i +: 4];
            end else begin
                res[4*i +: 4] = old_word[4*i +: 4];
            end
        end
        return res;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic            ready_r;
    logic            accept_s, oor_s, wr_s, rd_s, clr_s;
    logic [DW-1:0]   rdata_s;
    logic [DW-1:0]   mem_r [DEPTH];
    logic [DW-1:0]   dout1_r;
    logic            dv1_r, ae1_r;

    // Accesses are taken only while ACTIVE and no mode input is being sampled.
    assign accept_s = ready_r & CHIPSELECT & POWEROFF & ~SLEEP & ~STANDBY;
    assign oor_s    = ({1'b0, ADDRESS} >= DEPTH_LIM);
    assign wr_s     = accept_s & WREN & ~oor_s;
    assign rd_s     = accept_s & ~WREN;
    assign clr_s    = (state_nxt_s == ST_OFF) || (state_nxt_s == ST_SLEEP);

    // Next-state logic: !POWEROFF > SLEEP > STANDBY, wake countdown otherwise.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (!POWEROFF) begin
            state_nxt_s = ST_OFF;
        end else if (state_r == ST_OFF) begin
            state_nxt_s = OFF_TGT;
            cnt_nxt_s   = OFF_LD;
        end else if (SLEEP) begin
            state_nxt_s = ST_SLEEP;
        end else if (state_r == ST_SLEEP) begin
            state_nxt_s = SLEEP_TGT;
            cnt_nxt_s   = SLEEP_LD;
        end else if (STANDBY) begin
            state_nxt_s = ST_STBY;
        end else if (state_r == ST_STBY) begin
            state_nxt_s = STBY_TGT;
            cnt_nxt_s   = STBY_LD;
        end else if (state_r == ST_WAKE) begin
            if (cnt_r == {CW{1'b0}}) begin
                state_nxt_s = ST_ACTIVE;
            end else begin
                cnt_nxt_s = cnt_r - CW'(1);
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, wake counter and READY registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_WAKE;
            cnt_r   <= CW'(OFF_WAKE);
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= (state_nxt_s == ST_ACTIVE);
        end
    end

    // Read mux: out-of-range reads return zero.
    always_comb begin
        rdata_s = {DW{1'b0}};
        if (oor_s) begin
            rdata_s = {DW{1'b0}};
        end else begin
            rdata_s = mem_r[ADDRESS];
        end
    end

    // Storage array: survives reset, lost while powered off.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            if (!POWEROFF) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_r[i] <= {DW{1'bx}};
                end
            end else if (wr_s) begin
                mem_r[ADDRESS] <= merge_nibbles(mem_r[ADDRESS], DATAIN, MASKWREN);
            end
        end
    end

    // First output stage: read data held between reads, strobes pulse per access.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            dout1_r <= {DW{1'b0}};
            dv1_r   <= 1'b0;
            ae1_r   <= 1'b0;
        end else if (clr_s) begin
            dout1_r <= {DW{1'b0}};
            dv1_r   <= 1'b0;
            ae1_r   <= 1'b0;
        end else begin
            if (rd_s) begin
                dout1_r <= rdata_s;
            end
            dv1_r <= rd_s;
            ae1_r <= accept_s & oor_s;
        end
    end

`ifdef SPRAM_PM_OUTREG_EN
    // Second output stage, flushed together with the first on SLEEP/OFF entry.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            DATAOUT   <= {DW{1'b0}};
            DATAVALID <= 1'b0;
            ADDRERR   <= 1'b0;
        end else if (clr_s) begin
            DATAOUT   <= {DW{1'b0}};
            DATAVALID <= 1'b0;
            ADDRERR   <= 1'b0;
        end else begin
            DATAOUT   <= dout1_r;
            DATAVALID <= dv1_r;
            ADDRERR   <= ae1_r;
        end
    end
`else
    assign DATAOUT   = dout1_r;
    assign DATAVALID = dv1_r;
    assign ADDRERR   = ae1_r;
`endif

    assign READY = ready_r;

endmodule
